// File: rtl/alu_ctrl.sv
// alu_ctrl: three-state (IDLE/EXEC/WB) controller sequencing a 4 x 8 register
// file around an external combinational 8-bit ALU.
// Optional build macro ALU_CTRL_FLAGS_EN adds registered zero/negative flags.

package alu_ctrl_pkg;
  localparam int unsigned DW   = 8;
  localparam int unsigned AW   = 2;
  localparam int unsigned NREG = 4;
  localparam int unsigned IW   = 16;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_LDI = 2'b11;

  typedef struct packed {
    logic [1:0]    op;
    logic [AW-1:0] rd;
    logic [AW-1:0] rs1;
    logic [AW-1:0] rs2;
    logic [DW-1:0] imm;
  } instr_t;
endpackage

module alu_ctrl
  import alu_ctrl_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          instr_valid,
  output logic          instr_ready,
  input  logic [IW-1:0] instr,
  output logic [DW-1:0] alu_first,
  output logic [DW-1:0] alu_second,
  output logic          alu_mul,
  output logic          alu_sub,
  input  logic [DW-1:0] alu_result,
`ifdef ALU_CTRL_FLAGS_EN
  output logic          flag_z,
  output logic          flag_n,
`endif
  output logic          wb_valid,
  output logic [AW-1:0] wb_addr,
  output logic [DW-1:0] wb_data
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] WB   = 2'd2;

  logic [1:0]    state_q, state_nxt;
  instr_t        instr_q, instr_nxt;
  instr_t        instr_in;
  logic [DW-1:0] res_q, res_nxt;
  logic [DW-1:0] regs_q   [NREG];
  logic [DW-1:0] regs_nxt [NREG];

  logic          ready_nxt;
  logic [DW-1:0] first_nxt, second_nxt;
  logic          mul_nxt, sub_nxt;
  logic          wb_valid_nxt;
  logic [AW-1:0] wb_addr_nxt;
  logic [DW-1:0] wb_data_nxt;
`ifdef ALU_CTRL_FLAGS_EN
  logic          flag_z_nxt, flag_n_nxt;
`endif

  assign instr_in = instr_t'(instr);

  // Next-state and next-output logic; every output is the registered image of
  // what the following state must present.
  always_comb begin
    state_nxt    = state_q;
    instr_nxt    = instr_q;
    res_nxt      = res_q;
    regs_nxt     = regs_q;
    ready_nxt    = 1'b0;
    first_nxt    = '0;
    second_nxt   = '0;
    mul_nxt      = 1'b0;
    sub_nxt      = 1'b0;
    wb_valid_nxt = 1'b0;
    wb_addr_nxt  = '0;
    wb_data_nxt  = '0;
`ifdef ALU_CTRL_FLAGS_EN
    flag_z_nxt   = flag_z;
    flag_n_nxt   = flag_n;
`endif
    case (state_q)
      IDLE: begin
        if (instr_valid) begin
          instr_nxt = instr_in;
          state_nxt = EXEC;
          // Operands come from the register file as it stands at acceptance;
          // it cannot change again before this instruction's own write.
          if (instr_in.op != OP_LDI) begin
            first_nxt  = regs_q[instr_in.rs1];
            second_nxt = regs_q[instr_in.rs2];
            mul_nxt    = (instr_in.op == OP_MUL);
            sub_nxt    = (instr_in.op == OP_SUB);
          end
        end else begin
          ready_nxt = 1'b1;
        end
      end
      EXEC: begin
        res_nxt      = (instr_q.op == OP_LDI) ? instr_q.imm : alu_result;
        state_nxt    = WB;
        wb_valid_nxt = 1'b1;
        wb_addr_nxt  = instr_q.rd;
        wb_data_nxt  = res_nxt;
      end
      WB: begin
        regs_nxt[instr_q.rd] = res_q;
`ifdef ALU_CTRL_FLAGS_EN
        if (instr_q.op != OP_LDI) begin
          flag_z_nxt = (res_q == '0);
          flag_n_nxt = res_q[DW-1];
        end
`endif
        state_nxt = IDLE;
        ready_nxt = 1'b1;
      end
      default: begin
        state_nxt = IDLE;
        ready_nxt = 1'b1;
      end
    endcase
  end

  // State, register file and output registers; synchronous reset aborts any
  // instruction in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      instr_q     <= '0;
      res_q       <= '0;
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
      instr_ready <= 1'b1;
      alu_first   <= '0;
      alu_second  <= '0;
      alu_mul     <= 1'b0;
      alu_sub     <= 1'b0;
      wb_valid    <= 1'b0;
      wb_addr     <= '0;
      wb_data     <= '0;
`ifdef ALU_CTRL_FLAGS_EN
      flag_z      <= 1'b0;
      flag_n      <= 1'b0;
`endif
    end else begin
      state_q     <= state_nxt;
      instr_q     <= instr_nxt;
      res_q       <= res_nxt;
      for (int i = 0; i < NREG; i++) regs_q[i] <= regs_nxt[i];
      instr_ready <= ready_nxt;
      alu_first   <= first_nxt;
      alu_second  <= second_nxt;
      alu_mul     <= mul_nxt;
      alu_sub     <= sub_nxt;
      wb_valid    <= wb_valid_nxt;
      wb_addr     <= wb_addr_nxt;
      wb_data     <= wb_data_nxt;
`ifdef ALU_CTRL_FLAGS_EN
      flag_z      <= flag_z_nxt;
      flag_n      <= flag_n_nxt;
`endif
    end
  end

endmodule

// File: doc/alu_ctrl.md
ALU_CTRL -- requirements
Module: alu_ctrl

Interface
REQ-001 Parameters: none; datapath is fixed 8-bit signed, register file fixed 4 x 8.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 instr_valid  input  1  instruction word present on instr.
REQ-005 instr_ready  output  1  block accepts an instruction this cycle.
REQ-006 instr  input  16  op[15:14] (00 ADD, 01 SUB, 10 MUL, 11 LDI), rd[13:12], rs1[11:10], rs2[9:8], imm[7:0].
REQ-007 alu_first  output  8  signed operand A to downstream ALU.
REQ-008 alu_second  output  8  signed operand B to downstream ALU.
REQ-009 alu_mul  output  1  selects multiply in ALU.
REQ-010 alu_sub  output  1  selects subtract in ALU; ignored by ALU when alu_mul=1.
REQ-011 alu_result  input  8  signed combinational result from ALU.
REQ-012 wb_valid  output  1  one-cycle write-back pulse.
REQ-013 wb_addr  output  2  destination register of write-back.
REQ-014 wb_data  output  8  value written back.

Function
REQ-015 FSM states IDLE, EXEC, WB; instr_ready = 1 only in IDLE.
REQ-016 IDLE: on instr_valid=1 capture instr into internal register, go to EXEC; else stay IDLE.
REQ-017 EXEC: alu_first = reg[rs1], alu_second = reg[rs2], alu_mul = (op==MUL), alu_sub = (op==SUB); for LDI all four ALU outputs are 0.
REQ-018 EXEC: at clock edge latch alu_result (or imm for LDI) into result register; next state WB unconditionally.
REQ-019 Outside EXEC, alu_first, alu_second, alu_mul, alu_sub are 0.
REQ-020 WB: wb_valid=1, wb_addr=rd, wb_data=result register; reg[rd] updated at end of WB; next state IDLE.
REQ-021 wb_valid is 0 in every state other than WB; wb_addr/wb_data are 0 when wb_valid=0.
REQ-022 Latency: instruction accepted at edge N -> EXEC during cycle N+1 -> wb_valid during cycle N+2 -> instr_ready=1 during cycle N+3; throughput one instruction per 3 cycles.
REQ-023 Operand reads use register values before the current instruction's write; rd equal to rs1/rs2 is legal.
REQ-024 Arithmetic wraps modulo 2^8 (ALU returns low 8 bits); no saturation, no exception.
REQ-025 instr_valid and instr are ignored while instr_ready=0; instr may change freely during EXEC/WB.

Reset
REQ-026 rst=1 at an edge: state -> IDLE, all four registers -> 0, captured instruction and result register -> 0.
REQ-027 Cycle after reset: instr_ready=1, wb_valid=0, all ALU outputs 0, wb_addr=0, wb_data=0.
REQ-028 Reset in EXEC or WB aborts the instruction: no wb_valid pulse, no register write.

Configuration
REQ-029 Macro ALU_CTRL_FLAGS_EN: when defined, adds outputs flag_z (1 bit) and flag_n (1 bit), registered, updated at end of WB for ADD/SUB/MUL only: flag_z = (wb_data==0), flag_n = wb_data[7]; LDI leaves them unchanged; reset value 0.
REQ-030 Without ALU_CTRL_FLAGS_EN the ports flag_z/flag_n do not exist and all other behaviour is identical.

Verification
REQ-031 LDI r1,5; LDI r2,0xFD (-3); ADD r0=r1+r2 -> during EXEC alu_first=0x05, alu_second=0xFD, mul=0, sub=0; wb_valid pulse with wb_addr=0, wb_data=0x02.
REQ-032 SUB r3=r1-r2 -> alu_sub=1, wb_data=0x08; MUL r0=r1*r2 -> alu_mul=1, wb_data=0xF1 (-15).
REQ-033 Wrap: LDI r1,100; ADD r1=r1+r1 -> wb_data=0xC8; LDI r2,16; MUL r3=r2*r2 -> wb_data=0x00 (flag_z=1 with ALU_CTRL_FLAGS_EN).
REQ-034 Backpressure: hold instr_valid=1 with changing instr for 6 cycles -> exactly two instructions accepted, each at a cycle with instr_ready=1, wb_valid pulses 3 cycles apart.
REQ-035 Reset mid-op: assert rst during EXEC of ADD -> no wb_valid; next cycle instr_ready=1; reading r0..r3 via ADD r0=rX+rX yields 0x00.
REQ-036 With ALU_CTRL_FLAGS_EN: SUB giving 0xF8 -> flag_n=1, flag_z=0; subsequent LDI r0,0 -> flags unchanged.
